// File: rtl/mem_wb_pipe_pkg.sv
// Shared definitions for the MEM->WB pipeline register slice:
// stall-bit indices, default widths and the per-slot operation code.
package mem_wb_pipe_pkg;

   localparam int STALL_MEM  = 3;
   localparam int STALL_WB   = 4;
   localparam int DEF_DATA_W = 32;
   localparam int DEF_ADDR_W = 5;
   localparam int DEF_NUM_CH = 2;

   typedef enum logic [1:0] {
      SLOT_LOAD   = 2'd0,
      SLOT_HOLD   = 2'd1,
      SLOT_BUBBLE = 2'd2,
      SLOT_SQUASH = 2'd3
   } slot_op_e;

endpackage

// File: rtl/mem_wb_pipe_slot.sv
// wb_stage_slot: one MEM->WB stage register holding a write-back bundle.
// Ports: clk, rst (async active-low), op (load/hold/bubble/squash), in_* bundle, out_* bundle.
module wb_stage_slot
   import mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_CH = DEF_NUM_CH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  slot_op_e                 op,
   input  logic [NUM_CH*ADDR_W-1:0] in_waddr,
   input  logic [NUM_CH-1:0]        in_we,
   input  logic [NUM_CH*DATA_W-1:0] in_wdata,
   output logic [NUM_CH*ADDR_W-1:0] out_waddr,
   output logic [NUM_CH-1:0]        out_we,
   output logic [NUM_CH*DATA_W-1:0] out_wdata
);

   logic [NUM_CH*ADDR_W-1:0] waddr_q, waddr_d;
   logic [NUM_CH-1:0]        we_q, we_d;
   logic [NUM_CH*DATA_W-1:0] wdata_q, wdata_d;

   always_comb begin
      waddr_d = waddr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      unique case (op)
         SLOT_LOAD: begin
            waddr_d = in_waddr;
            we_d    = in_we;
            wdata_d = in_wdata;
         end
         SLOT_BUBBLE: begin
            waddr_d = '0;
            we_d    = '0;
            wdata_d = '0;
         end
         // Squash only kills the enables; addr/data stay put.
         SLOT_SQUASH: we_d = '0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         waddr_q <= '0;
         we_q    <= '0;
         wdata_q <= '0;
      end else begin
         waddr_q <= waddr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
      end
   end

   assign out_waddr = waddr_q;
   assign out_we    = we_q;
   assign out_wdata = wdata_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: DEPTH-stage MEM->WB register chain with write sanitising, retire counter
// and optional forwarding (macro WB_BYPASS_EN: rd_addr/fwd_hit/fwd_data). Ports: mem_* in, wb_* out.
module mem_wb_pipe
   import mem_wb_pipe_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_CH = DEF_NUM_CH,
   parameter int DEPTH  = 1,
   parameter int NUM_RD = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH*ADDR_W-1:0] mem_waddr,
   input  logic [NUM_CH-1:0]        mem_we,
   input  logic [NUM_CH*DATA_W-1:0] mem_wdata,
   input  logic [4:0]               stall,
   input  logic                     flush,
`ifdef WB_BYPASS_EN
   input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
   output logic [NUM_RD-1:0]        fwd_hit,
   output logic [NUM_RD*DATA_W-1:0] fwd_data,
`endif
   output logic [NUM_CH*ADDR_W-1:0] wb_waddr,
   output logic [NUM_CH-1:0]        wb_we,
   output logic [NUM_CH*DATA_W-1:0] wb_wdata,
   output logic [31:0]              wb_cnt
);

   logic [NUM_CH*ADDR_W-1:0] st_waddr [DEPTH];
   logic [NUM_CH-1:0]        st_we    [DEPTH];
   logic [NUM_CH*DATA_W-1:0] st_wdata [DEPTH];
   logic [NUM_CH-1:0]        cap_we;
   slot_op_e                 op_head, op_tail;
   logic [31:0]              wb_cnt_q, wb_cnt_d, ret_n;
   logic [2:0]               unused_stall;

   assign unused_stall = stall[2:0];

   // Drop x0 writes, and drop a lower channel shadowed by a higher one.
   always_comb begin
      cap_we = mem_we;
      for (int c = 0; c < NUM_CH; c++) begin
         if (mem_waddr[c*ADDR_W +: ADDR_W] == '0)
            cap_we[c] = 1'b0;
         for (int j = c + 1; j < NUM_CH; j++)
            if (mem_we[j] &&
                mem_waddr[j*ADDR_W +: ADDR_W] == mem_waddr[c*ADDR_W +: ADDR_W])
               cap_we[c] = 1'b0;
      end
   end

   always_comb begin
      op_head = SLOT_LOAD;
      op_tail = SLOT_LOAD;
      if (flush) begin
         op_head = SLOT_SQUASH;
         op_tail = SLOT_SQUASH;
      end else if (stall[STALL_WB]) begin
         op_head = SLOT_HOLD;
         op_tail = SLOT_HOLD;
      end else if (stall[STALL_MEM]) begin
         op_head = SLOT_BUBBLE;
      end
   end

   for (genvar s = 0; s < DEPTH; s++) begin : g_slot
      if (s == 0) begin : g_head
         wb_stage_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .op        (op_head),
            .in_waddr  (mem_waddr),
            .in_we     (cap_we),
            .in_wdata  (mem_wdata),
            .out_waddr (st_waddr[s]),
            .out_we    (st_we[s]),
            .out_wdata (st_wdata[s])
         );
      end else begin : g_tail
         wb_stage_slot #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_CH(NUM_CH)) u_slot (
            .clk       (clk),
            .rst       (rst),
            .op        (op_tail),
            .in_waddr  (st_waddr[s-1]),
            .in_we     (st_we[s-1]),
            .in_wdata  (st_wdata[s-1]),
            .out_waddr (st_waddr[s]),
            .out_we    (st_we[s]),
            .out_wdata (st_wdata[s])
         );
      end
   end

   assign wb_waddr = st_waddr[DEPTH-1];
   assign wb_we    = st_we[DEPTH-1];
   assign wb_wdata = st_wdata[DEPTH-1];

   always_comb begin
      ret_n = '0;
      for (int c = 0; c < NUM_CH; c++)
         ret_n = ret_n + 32'(wb_we[c]);
      wb_cnt_d = wb_cnt_q;
      if (!flush && !stall[STALL_WB])
         wb_cnt_d = wb_cnt_q + ret_n;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) wb_cnt_q <= '0;
      else      wb_cnt_q <= wb_cnt_d;
   end

   assign wb_cnt = wb_cnt_q;

`ifdef WB_BYPASS_EN
   // Walk oldest->youngest, low->high channel: the last match wins.
   always_comb begin
      fwd_hit  = '0;
      fwd_data = '0;
      for (int r = 0; r < NUM_RD; r++)
         for (int s = DEPTH - 1; s >= 0; s--)
            for (int c = 0; c < NUM_CH; c++)
               if (rd_addr[r*ADDR_W +: ADDR_W] != '0 && st_we[s][c] &&
                   st_waddr[s][c*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W]) begin
                  fwd_hit[r] = 1'b1;
                  fwd_data[r*DATA_W +: DATA_W] = st_wdata[s][c*DATA_W +: DATA_W];
               end
   end
`else
   localparam int unused_num_rd = NUM_RD;
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Directed testbench for mem_wb_pipe: three instances (DEPTH 1, 2, 3) share one stimulus bus.
// Forwarding checks are compiled in when WB_BYPASS_EN is defined.
module tb_mem_wb_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  mem_waddr = '0;
   logic [1:0]  mem_we = '0;
   logic [63:0] mem_wdata = '0;
   logic [4:0]  stall = '0;
   logic        flush = 1'b0;
   logic [9:0]  rd_addr = '0;

   logic [9:0]  a1, a2, a3;
   logic [1:0]  w1, w2, w3;
   logic [63:0] d1, d2, d3;
   logic [31:0] c1, c2, c3;
   logic [1:0]  h1, h2, h3;
   logic [63:0] f1, f2, f3;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_wb_pipe #(.DEPTH(1)) u1 (
      .clk(clk), .rst(rst), .mem_waddr(mem_waddr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .stall(stall), .flush(flush),
`ifdef WB_BYPASS_EN
      .rd_addr(rd_addr), .fwd_hit(h1), .fwd_data(f1),
`endif
      .wb_waddr(a1), .wb_we(w1), .wb_wdata(d1), .wb_cnt(c1));

   mem_wb_pipe #(.DEPTH(2)) u2 (
      .clk(clk), .rst(rst), .mem_waddr(mem_waddr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .stall(stall), .flush(flush),
`ifdef WB_BYPASS_EN
      .rd_addr(rd_addr), .fwd_hit(h2), .fwd_data(f2),
`endif
      .wb_waddr(a2), .wb_we(w2), .wb_wdata(d2), .wb_cnt(c2));

   mem_wb_pipe #(.DEPTH(3)) u3 (
      .clk(clk), .rst(rst), .mem_waddr(mem_waddr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .stall(stall), .flush(flush),
`ifdef WB_BYPASS_EN
      .rd_addr(rd_addr), .fwd_hit(h3), .fwd_data(f3),
`endif
      .wb_waddr(a3), .wb_we(w3), .wb_wdata(d3), .wb_cnt(c3));

`ifndef WB_BYPASS_EN
   assign h1 = '0; assign h2 = '0; assign h3 = '0;
   assign f1 = '0; assign f2 = '0; assign f3 = '0;
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] ad1, input logic [4:0] ad0,
                        input logic [1:0] we, input logic [31:0] dt1,
                        input logic [31:0] dt0);
      mem_waddr = {ad1, ad0};
      mem_we    = we;
      mem_wdata = {dt1, dt0};
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      drive(5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
      stall = '0;
      flush = 1'b0;
      #1;
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_reset();
      #2 rst = 1'b0;
      #1;
      n_chk++; if (w1 !== 2'b00) begin n_err++; $display("FAIL rst_we1 got %b exp %b", w1, 2'b00); end
      n_chk++; if (c1 !== 32'd0) begin n_err++; $display("FAIL rst_cnt1 got %h exp %h", c1, 32'd0); end
      n_chk++; if (a3 !== 10'd0) begin n_err++; $display("FAIL rst_addr3 got %h exp %h", a3, 10'd0); end
      n_chk++; if (d3 !== 64'd0) begin n_err++; $display("FAIL rst_data3 got %h exp %h", d3, 64'd0); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_basic();
      apply_reset();
      drive(5'd6, 5'd5, 2'b11, 32'hBBBB_0002, 32'hAAAA_0001);
      tick();
      n_chk++; if (w1 !== 2'b11) begin n_err++; $display("FAIL basic_we got %b exp %b", w1, 2'b11); end
      n_chk++; if (a1 !== {5'd6, 5'd5}) begin n_err++; $display("FAIL basic_addr got %h exp %h", a1, {5'd6, 5'd5}); end
      n_chk++; if (d1 !== 64'hBBBB_0002_AAAA_0001) begin n_err++; $display("FAIL basic_data got %h exp %h", d1, 64'hBBBB_0002_AAAA_0001); end
      n_chk++; if (c1 !== 32'd0) begin n_err++; $display("FAIL basic_cnt0 got %0d exp %0d", c1, 0); end
      n_chk++; if (w2 !== 2'b00) begin n_err++; $display("FAIL lat2_early got %b exp %b", w2, 2'b00); end
      drive(5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
      tick();
      n_chk++; if (c1 !== 32'd2) begin n_err++; $display("FAIL basic_cnt got %0d exp %0d", c1, 2); end
      n_chk++; if (w1 !== 2'b00) begin n_err++; $display("FAIL basic_idle got %b exp %b", w1, 2'b00); end
      n_chk++; if (w2 !== 2'b11) begin n_err++; $display("FAIL lat2_we got %b exp %b", w2, 2'b11); end
      n_chk++; if (d2 !== 64'hBBBB_0002_AAAA_0001) begin n_err++; $display("FAIL lat2_data got %h exp %h", d2, 64'hBBBB_0002_AAAA_0001); end
      n_chk++; if (w3 !== 2'b00) begin n_err++; $display("FAIL lat3_early got %b exp %b", w3, 2'b00); end
      tick();
      n_chk++; if (w3 !== 2'b11) begin n_err++; $display("FAIL lat3_we got %b exp %b", w3, 2'b11); end
      n_chk++; if (a3 !== {5'd6, 5'd5}) begin n_err++; $display("FAIL lat3_addr got %h exp %h", a3, {5'd6, 5'd5}); end
      n_chk++; if (c1 !== 32'd2) begin n_err++; $display("FAIL basic_cnt_hold got %0d exp %0d", c1, 2); end
   endtask

   task automatic test_collide();
      apply_reset();
      drive(5'd7, 5'd7, 2'b11, 32'h2, 32'h1);
      tick();
      n_chk++; if (w1 !== 2'b10) begin n_err++; $display("FAIL coll_we got %b exp %b", w1, 2'b10); end
      n_chk++; if (d1[63:32] !== 32'h2) begin n_err++; $display("FAIL coll_data got %h exp %h", d1[63:32], 32'h2); end
      drive(5'd0, 5'd0, 2'b11, 32'h4, 32'h3);
      tick();
      n_chk++; if (w1 !== 2'b00) begin n_err++; $display("FAIL x0_we got %b exp %b", w1, 2'b00); end
      n_chk++; if (c1 !== 32'd1) begin n_err++; $display("FAIL coll_cnt got %0d exp %0d", c1, 1); end
      drive(5'd4, 5'd4, 2'b01, 32'h6, 32'h5);
      tick();
      n_chk++; if (c1 !== 32'd1) begin n_err++; $display("FAIL x0_cnt got %0d exp %0d", c1, 1); end
      n_chk++; if (w1 !== 2'b01) begin n_err++; $display("FAIL noshadow_we got %b exp %b", w1, 2'b01); end
   endtask

   task automatic test_bubble();
      apply_reset();
      for (int n = 1; n <= 9; n++) begin
         drive(5'd2, 5'd1, 2'b11, 32'h100 + 32'(n), 32'(n));
         stall = (n == 3) ? 5'b01000 : ((n == 7 || n == 8) ? 5'b10000 : 5'b00000);
         if (n == 9) drive(5'd2, 5'd1, 2'b11, 32'h107, 32'h7);
         tick();
         case (n)
            3: begin
               n_chk++; if (d3 !== 64'h101_0000_0001) begin n_err++; $display("FAIL bub_b1 got %h exp %h", d3, 64'h101_0000_0001); end
            end
            5: begin
               n_chk++; if (w3 !== 2'b00) begin n_err++; $display("FAIL bub_we got %b exp %b", w3, 2'b00); end
               n_chk++; if (a3 !== 10'd0) begin n_err++; $display("FAIL bub_addr got %h exp %h", a3, 10'd0); end
               n_chk++; if (d3 !== 64'd0) begin n_err++; $display("FAIL bub_data got %h exp %h", d3, 64'd0); end
               n_chk++; if (c3 !== 32'd4) begin n_err++; $display("FAIL bub_cnt5 got %0d exp %0d", c3, 4); end
            end
            6: begin
               n_chk++; if (d3 !== 64'h104_0000_0004) begin n_err++; $display("FAIL bub_b4 got %h exp %h", d3, 64'h104_0000_0004); end
               n_chk++; if (c3 !== 32'd4) begin n_err++; $display("FAIL bub_cnt6 got %0d exp %0d", c3, 4); end
            end
            7, 8: begin
               n_chk++; if (d3 !== 64'h104_0000_0004) begin n_err++; $display("FAIL wbstall_data got %h exp %h", d3, 64'h104_0000_0004); end
               n_chk++; if (w3 !== 2'b11) begin n_err++; $display("FAIL wbstall_we got %b exp %b", w3, 2'b11); end
               n_chk++; if (c3 !== 32'd4) begin n_err++; $display("FAIL wbstall_cnt got %0d exp %0d", c3, 4); end
            end
            9: begin
               n_chk++; if (d3 !== 64'h105_0000_0005) begin n_err++; $display("FAIL resume_data got %h exp %h", d3, 64'h105_0000_0005); end
               n_chk++; if (c3 !== 32'd6) begin n_err++; $display("FAIL resume_cnt got %0d exp %0d", c3, 6); end
            end
            default: ;
         endcase
      end
      stall = '0;
   endtask

   task automatic test_flush();
      apply_reset();
      drive(5'd0, 5'd9, 2'b01, 32'h0, 32'h33);
      tick();
      drive(5'd0, 5'd9, 2'b01, 32'h0, 32'h55);
      tick();
      n_chk++; if (w2 !== 2'b01) begin n_err++; $display("FAIL fl_pre_we got %b exp %b", w2, 2'b01); end
      n_chk++; if (d2[31:0] !== 32'h33) begin n_err++; $display("FAIL fl_pre_data got %h exp %h", d2[31:0], 32'h33); end
`ifdef WB_BYPASS_EN
      rd_addr = {5'd0, 5'd9};
      #1;
      n_chk++; if (h2 !== 2'b01) begin n_err++; $display("FAIL fwd_hit got %b exp %b", h2, 2'b01); end
      n_chk++; if (f2 !== 64'h55) begin n_err++; $display("FAIL fwd_data got %h exp %h", f2, 64'h55); end
      rd_addr = {5'd3, 5'd9};
      #1;
      n_chk++; if (h2 !== 2'b01) begin n_err++; $display("FAIL fwd_miss_hit got %b exp %b", h2, 2'b01); end
      n_chk++; if (f2[63:32] !== 32'h0) begin n_err++; $display("FAIL fwd_miss_data got %h exp %h", f2[63:32], 32'h0); end
`endif
      drive(5'd0, 5'd9, 2'b01, 32'h0, 32'h77);
      flush = 1'b1;
      stall = 5'b10000;
      tick();
      n_chk++; if (w2 !== 2'b00) begin n_err++; $display("FAIL fl_we got %b exp %b", w2, 2'b00); end
      n_chk++; if (a2[4:0] !== 5'd9) begin n_err++; $display("FAIL fl_addr got %h exp %h", a2[4:0], 5'd9); end
      n_chk++; if (d2[31:0] !== 32'h33) begin n_err++; $display("FAIL fl_data got %h exp %h", d2[31:0], 32'h33); end
      n_chk++; if (c2 !== 32'd0) begin n_err++; $display("FAIL fl_cnt got %0d exp %0d", c2, 0); end
`ifdef WB_BYPASS_EN
      rd_addr = {5'd0, 5'd9};
      #1;
      n_chk++; if (h2 !== 2'b00) begin n_err++; $display("FAIL fwd_flush got %b exp %b", h2, 2'b00); end
`endif
      flush = 1'b0;
      stall = '0;
      drive(5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
      tick();
      n_chk++; if (d2[31:0] !== 32'h55) begin n_err++; $display("FAIL fl_s0_hold got %h exp %h", d2[31:0], 32'h55); end
      n_chk++; if (w2 !== 2'b00) begin n_err++; $display("FAIL fl_s0_we got %b exp %b", w2, 2'b00); end
      n_chk++; if (c2 !== 32'd0) begin n_err++; $display("FAIL fl_cnt2 got %0d exp %0d", c2, 0); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      drive(5'd2, 5'd1, 2'b11, 32'h22, 32'h11);
      tick(); tick(); tick();
      n_chk++; if (w3 !== 2'b11) begin n_err++; $display("FAIL ar_full got %b exp %b", w3, 2'b11); end
      #3 rst = 1'b0;
      #1;
      n_chk++; if (w3 !== 2'b00) begin n_err++; $display("FAIL ar_we got %b exp %b", w3, 2'b00); end
      n_chk++; if (c1 !== 32'd0) begin n_err++; $display("FAIL ar_cnt got %0d exp %0d", c1, 0); end
      @(negedge clk);
      drive(5'd0, 5'd3, 2'b01, 32'h0, 32'h123);
      rst = 1'b1;
      tick();
      n_chk++; if (w1 !== 2'b01) begin n_err++; $display("FAIL ar_first_we got %b exp %b", w1, 2'b01); end
      n_chk++; if (d1[31:0] !== 32'h123) begin n_err++; $display("FAIL ar_first_data got %h exp %h", d1[31:0], 32'h123); end
      drive(5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
      tick();
      n_chk++; if (w3 !== 2'b00) begin n_err++; $display("FAIL ar_stale got %b exp %b", w3, 2'b00); end
      tick();
      n_chk++; if (w3 !== 2'b01) begin n_err++; $display("FAIL ar_new_we got %b exp %b", w3, 2'b01); end
      n_chk++; if (d3[31:0] !== 32'h123) begin n_err++; $display("FAIL ar_new_data got %h exp %h", d3[31:0], 32'h123); end
   endtask

   task automatic test_wrap();
      apply_reset();
      #1;
      force u1.wb_cnt_q = 32'hFFFF_FFFF;
      #1;
      release u1.wb_cnt_q;
      drive(5'd2, 5'd1, 2'b11, 32'hB, 32'hA);
      tick();
      n_chk++; if (c1 !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_pre got %h exp %h", c1, 32'hFFFF_FFFF); end
      drive(5'd0, 5'd0, 2'b00, 32'h0, 32'h0);
      tick();
      n_chk++; if (c1 !== 32'd1) begin n_err++; $display("FAIL wrap_cnt got %h exp %h", c1, 32'd1); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_collide();
      test_bubble();
      test_flush();
      test_async_reset();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running exp finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_wb_pipe.md
MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning write-back data width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning register address width.
REQ-003 SHALL have parameter NUM_CH, default 2, meaning write-back channels per bundle.
REQ-004 SHALL have parameter DEPTH, default 1, legal range 1..4, meaning register stages between the MEM and WB stages.
REQ-005 SHALL have parameter NUM_RD, default 2, meaning forwarding read ports.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 mem_waddr  in  NUM_CH*ADDR_W  per-channel destination address; channel c occupies bits [c*ADDR_W +: ADDR_W].
REQ-009 mem_we  in  NUM_CH  per-channel write enable.
REQ-010 mem_wdata  in  NUM_CH*DATA_W  per-channel write data.
REQ-011 stall  in  5  pipeline stall vector; bit 3 is MEM, bit 4 is WB.
REQ-012 flush  in  1  squash all in-flight bundles.
REQ-013 wb_waddr / wb_we / wb_wdata  out  NUM_CH*ADDR_W / NUM_CH / NUM_CH*DATA_W  oldest-stage bundle to the register file.
REQ-014 wb_cnt  out  32  count of retired channel writes.
REQ-015 rd_addr  in  NUM_RD*ADDR_W  forwarding lookup addresses (WB_BYPASS_EN only).
REQ-016 fwd_hit / fwd_data  out  NUM_RD / NUM_RD*DATA_W  forwarding result per read port (WB_BYPASS_EN only).

Function
REQ-017 Stages S0..S(DEPTH-1); S0 captures mem_*; the wb_* outputs are S(DEPTH-1) registered, giving a latency of DEPTH cycles.
REQ-018 Priority per cycle: flush, then stall[4], then bubble, then advance.
REQ-019 When flush=1, all stage we bits SHALL be 0 next cycle; addr and data SHALL hold their values; wb_cnt SHALL not increment.
REQ-020 When stall[4]=1, all stages SHALL hold their values.
REQ-021 When stall[3]=1 and stall[4]=0, S0 SHALL load a bubble (all we=0, addr=0, data=0) and S1..S(DEPTH-1) SHALL advance.
REQ-022 Otherwise, all stages SHALL advance by one.
REQ-023 At capture, a channel with waddr==0 SHALL have its we forced to 0.
REQ-024 At capture, if channels i<j both write the same address, channel i's we SHALL be forced to 0, so the higher channel wins.
REQ-025 wb_cnt SHALL increment by popcount(wb_we) on each cycle with stall[4]=0 and flush=0, and SHALL wrap modulo 2^32.
REQ-026 Forwarding: fwd_hit[r] is 1 when any stage holds a channel with we=1 and addr==rd_addr[r]; the youngest stage wins, and within a stage the highest channel wins; fwd_data=0 on a miss; fwd_hit=0 when rd_addr==0; the path is purely combinational.

Reset
REQ-027 While rst=0, all stage registers, wb_* and wb_cnt SHALL be 0 immediately, with no clock required.
REQ-028 After rst releases mid-operation, the first capture SHALL occur on the next rising edge; no pre-reset data SHALL reappear.

Configuration
REQ-029 Macro WB_BYPASS_EN: when defined, rd_addr, fwd_hit, fwd_data and the match logic SHALL exist; when undefined, those ports and that logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-030 The shared defines file SHALL hold the stall-bit indices (STALL_MEM=3, STALL_WB=4) and default widths; the `RegBus/`RegAddrBus style macros are reused as defaults.
REQ-031 One sub-module, wb_stage_slot, SHALL implement a single stage register (hold/bubble/load/squash); it is instantiated DEPTH times by a generate loop.

Verification
REQ-032 DEPTH=1, NUM_CH=2: ch0 (addr 5, 0xAAAA_0001, we=1), ch1 (addr 6, 0xBBBB_0002, we=1) -> next cycle wb_we=2'b11 with those values; wb_cnt=2.
REQ-033 ch0 and ch1 both addr 7 (0x1 and 0x2, we=1) -> wb_we=2'b10, wb_wdata ch1=0x2; addr 0 with we=1 -> we=0; wb_cnt +1 for the first bundle, +0 for the second.
REQ-034 DEPTH=3: stall=5'b01000 for 1 cycle amid back-to-back writes -> a single all-zero bubble appears on wb_* 3 cycles later; stall=5'b10000 for 2 cycles -> wb_* frozen for 2 cycles and wb_cnt unchanged.
REQ-035 DEPTH=2, writes to addr 9 in S0 (0x55) and S1 (0x33), with flush=1 and stall[4]=1 in the same cycle -> flush wins: all we=0 next cycle, wb_cnt unchanged.
REQ-036 WB_BYPASS_EN, DEPTH=2: S1 holds addr 9 = 0x33 and S0 holds addr 9 = 0x55; rd_addr=9 -> fwd_hit=1, fwd_data=0x55; rd_addr=0 -> fwd_hit=0.
REQ-037 Assert rst=0 between clock edges with stages full -> wb_we=0 and wb_cnt=0 immediately; wb_cnt=0xFFFF_FFFF plus 2 retirements -> wb_cnt=1.
